// File: rtl/matmul_tile_sched.sv
// Tile sequencer for the matmul_int array: walks an m x n grid of output tiles in
// row-major order, requesting operands, timing the datapath and handing off results.
module matmul_tile_sched #(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [IDX_W-1:0] i_cfg_m,
    input  logic [IDX_W-1:0] i_cfg_n,
    output logic             o_busy,
    output logic             o_ld_valid,
    input  logic             i_ld_ready,
    output logic [IDX_W-1:0] o_row_tile,
    output logic [IDX_W-1:0] o_col_tile,
    output logic             o_dp_en,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic             o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [7:0]       CNT_LOAD = 8'(LATENCY);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] m_q, m_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             last_col;
    logic             last_row;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            n_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        n_d      = n_q;
        row_d    = row_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        last_col = (col_q == n_q - IDX_ONE);
        last_row = (row_q == m_q - IDX_ONE);

        // Abort outranks everything, including a start seen in IDLE.
        if (i_abort) begin
            state_d = S_IDLE;
            row_d   = '0;
            col_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        m_d   = i_cfg_m;
                        n_d   = i_cfg_n;
                        row_d = '0;
                        col_d = '0;
                        if (i_cfg_m == '0 || i_cfg_n == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (i_ld_ready) begin
                        cnt_d   = CNT_LOAD;
                        state_d = S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (i_res_ready) begin
                        if (last_col) begin
                            col_d = '0;
                            row_d = row_q + IDX_ONE;
                        end else begin
                            col_d = col_q + IDX_ONE;
                        end
                        if (last_row && last_col) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode the state alone, so ready inputs never loop back combinationally.
    assign o_busy      = (state_q != S_IDLE);
    assign o_ld_valid  = (state_q == S_LOAD);
    assign o_dp_en     = (state_q == S_COMPUTE);
    assign o_res_valid = (state_q == S_WRITE);
    assign o_done      = (state_q == S_DONE);
    assign o_row_tile  = row_q;
    assign o_col_tile  = col_q;

endmodule

// File: tb/tb_matmul_tile_sched.sv
// Self-checking bench for matmul_tile_sched: a per-cycle expected trace is built
// from the tile walk arithmetic, then replayed against the DUT.
module tb_matmul_tile_sched;

    localparam int LAT = 4;
    localparam int IW  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          ld_ready;
    logic          res_ready;
    logic [IW-1:0] cfg_m;
    logic [IW-1:0] cfg_n;
    logic          busy;
    logic          ld_valid;
    logic          dp_en;
    logic          res_valid;
    logic          done;
    logic [IW-1:0] row_tile;
    logic [IW-1:0] col_tile;

    always #5 clk = ~clk;

    matmul_tile_sched #(.LATENCY(LAT), .IDX_W(IW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_abort    (abort),
        .i_cfg_m    (cfg_m),
        .i_cfg_n    (cfg_n),
        .o_busy     (busy),
        .o_ld_valid (ld_valid),
        .i_ld_ready (ld_ready),
        .o_row_tile (row_tile),
        .o_col_tile (col_tile),
        .o_dp_en    (dp_en),
        .o_res_valid(res_valid),
        .i_res_ready(res_ready),
        .o_done     (done)
    );

    typedef struct {
        logic          start;
        logic          abort;
        logic          ld_rdy;
        logic          res_rdy;
        logic [IW-1:0] cfg_m;
        logic [IW-1:0] cfg_n;
        logic          busy;
        logic          ld_v;
        logic          dp;
        logic          res_v;
        logic          done;
        logic [IW-1:0] row;
        logic [IW-1:0] col;
    } vec_t;

    vec_t          vecs[$];
    logic [IW-1:0] held_row = '0;
    logic [IW-1:0] held_col = '0;
    int            checks   = 0;
    int            errors   = 0;
    int            hs_count;
    int            dp_count;
    int            ld_count;
    int            res_count;
    int            done_count;
    int            off;

    // phase: 0 idle, 1 load, 2 compute, 3 write, 4 done
    task automatic pushVec(input logic st, input logic ab, input logic ldr, input logic rsr,
                           input logic [IW-1:0] cm, input logic [IW-1:0] cn,
                           input int phase, input logic [IW-1:0] r, input logic [IW-1:0] c);
        vec_t v;
        v.start   = st;
        v.abort   = ab;
        v.ld_rdy  = ldr;
        v.res_rdy = rsr;
        v.cfg_m   = cm;
        v.cfg_n   = cn;
        v.busy    = (phase != 0);
        v.ld_v    = (phase == 1);
        v.dp      = (phase == 2);
        v.res_v   = (phase == 3);
        v.done    = (phase == 4);
        v.row     = r;
        v.col     = c;
        vecs.push_back(v);
    endtask

    task automatic pushIdle(input int count);
        for (int i = 0; i < count; i++) begin
            pushVec(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, 0, held_row, held_col);
        end
    endtask

    // Expected trace of one job: tile t sits at (t/n, t%n); each tile spends
    // 1+ld_stall cycles requesting, LAT computing and 1+res_stall writing.
    task automatic buildJob(input int m, input int n, input int ld_stall, input int res_stall,
                            input int abort_tile, input logic poke_start, output int done_off);
        int base;
        base = vecs.size();
        done_off = -1;
        pushVec(1'b1, 1'b0, 1'b1, 1'b1, IW'(m), IW'(n), 0, held_row, held_col);
        held_row = '0;
        held_col = '0;
        if (m == 0 || n == 0) begin
            pushVec(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, 4, '0, '0);
            done_off = vecs.size() - 1 - base;
            return;
        end
        for (int t = 0; t < m * n; t++) begin
            logic [IW-1:0] r;
            logic [IW-1:0] c;
            r = IW'(t / n);
            c = IW'(t % n);
            for (int s = 0; s <= ld_stall; s++) begin
                pushVec(1'b0, 1'b0, (s == ld_stall), 1'b1, '0, '0, 1, r, c);
            end
            for (int k = 0; k < LAT; k++) begin
                if (poke_start && t == 0 && k == 0) begin
                    pushVec(1'b1, 1'b0, 1'b1, 1'b1, 8'd9, 8'd9, 2, r, c);
                end else begin
                    pushVec(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, 2, r, c);
                end
            end
            for (int s = 0; s <= res_stall; s++) begin
                if (t == abort_tile && s == res_stall) begin
                    pushVec(1'b0, 1'b1, 1'b1, 1'b1, '0, '0, 3, r, c);
                    held_row = '0;
                    held_col = '0;
                    return;
                end
                pushVec(1'b0, 1'b0, 1'b1, (s == res_stall), '0, '0, 3, r, c);
            end
        end
        // The final accept wraps col to 0 and bumps row to m, which then holds.
        pushVec(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, 4, IW'(m), '0);
        done_off = vecs.size() - 1 - base;
        held_row = IW'(m);
        held_col = '0;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        checks++;
        if ({busy, ld_valid, dp_en, res_valid, done, row_tile, col_tile} !==
            {v.busy, v.ld_v, v.dp, v.res_v, v.done, v.row, v.col}) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got busy=%b ld=%b dp=%b res=%b done=%b row=%0d col=%0d, expected busy=%b ld=%b dp=%b res=%b done=%b row=%0d col=%0d",
                     name, $time, busy, ld_valid, dp_en, res_valid, done, row_tile, col_tile,
                     v.busy, v.ld_v, v.dp, v.res_v, v.done, v.row, v.col);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic clearCounts();
        hs_count   = 0;
        dp_count   = 0;
        ld_count   = 0;
        res_count  = 0;
        done_count = 0;
    endtask

    // Replays the queued trace: compare the outputs of the cycle, then drive its inputs.
    task automatic applyStimulus(input string name);
        vec_t v;
        while (vecs.size() > 0) begin
            v = vecs.pop_front();
            @(negedge clk);
            checkOutput(v, name);
            start     = v.start;
            abort     = v.abort;
            ld_ready  = v.ld_rdy;
            res_ready = v.res_rdy;
            cfg_m     = v.cfg_m;
            cfg_n     = v.cfg_n;
            if (res_valid && res_ready) hs_count++;
            if (dp_en) dp_count++;
            if (ld_valid) ld_count++;
            if (res_valid) res_count++;
            if (done) done_count++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        bit   found;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        ld_ready  = 1'b1;
        res_ready = 1'b1;
        cfg_m     = '0;
        cfg_n     = '0;
        #3;
        pushVec(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, 0, '0, '0);
        v = vecs.pop_front();
        checkOutput(v, "reset_values");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic 2x3 job");
        clearCounts();
        buildJob(2, 3, 0, 0, -1, 1'b0, off);
        checkValue("model_2x3_done_offset", off, 37);
        pushIdle(2);
        applyStimulus("basic_2x3");
        checkValue("basic_2x3_handshakes", hs_count, 6);
        checkValue("basic_2x3_dp_cycles", dp_count, 24);
        checkValue("basic_2x3_done_pulses", done_count, 1);

        $display("[TB] zero-size job");
        clearCounts();
        buildJob(0, 5, 0, 0, -1, 1'b0, off);
        checkValue("model_zero_done_offset", off, 1);
        pushIdle(2);
        applyStimulus("zero_job");
        checkValue("zero_job_ld_cycles", ld_count, 0);
        checkValue("zero_job_dp_cycles", dp_count, 0);
        checkValue("zero_job_res_cycles", res_count, 0);
        checkValue("zero_job_done_pulses", done_count, 1);

        $display("[TB] backpressure 1x1 job");
        clearCounts();
        buildJob(1, 1, 5, 3, -1, 1'b0, off);
        checkValue("model_backpressure_done_offset", off, 15);
        pushIdle(2);
        applyStimulus("backpressure");
        checkValue("backpressure_handshakes", hs_count, 1);

        $display("[TB] start while busy, 1x2 job");
        clearCounts();
        buildJob(1, 2, 0, 0, -1, 1'b1, off);
        checkValue("model_busy_start_done_offset", off, 13);
        pushIdle(3);
        applyStimulus("start_while_busy");
        checkValue("start_while_busy_handshakes", hs_count, 2);
        checkValue("start_while_busy_done_pulses", done_count, 1);

        $display("[TB] abort during write of tile (0,1)");
        clearCounts();
        buildJob(2, 2, 0, 0, 1, 1'b0, off);
        pushIdle(2);
        pushVec(1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 0, '0, '0);
        pushIdle(2);
        applyStimulus("abort_write");
        checkValue("abort_write_done_pulses", done_count, 0);

        clearCounts();
        buildJob(1, 1, 0, 0, -1, 1'b0, off);
        checkValue("model_after_abort_done_offset", off, 7);
        pushIdle(2);
        applyStimulus("after_abort");
        checkValue("after_abort_done_pulses", done_count, 1);

        $display("[TB] asynchronous reset during compute");
        @(negedge clk);
        start = 1'b1;
        cfg_m = 8'd1;
        cfg_n = 8'd2;
        @(negedge clk);
        start = 1'b0;
        cfg_m = '0;
        cfg_n = '0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dp_en && col_tile == 8'd1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL reach_compute_tile1: got no compute of tile (0,1), expected one within 40 cycles");
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        pushVec(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, 0, '0, '0);
        v = vecs.pop_front();
        checkOutput(v, "async_reset_immediate");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        held_row = '0;
        held_col = '0;
        pushIdle(4);
        applyStimulus("after_reset_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
